// File: rtl/result_normalizer.sv
// -----------------------------------------------------------------------------
// result_normalizer
//   Two-stage pipelined normaliser feeding result_rounder. It takes a raw
//   significand and its biased exponent. It normalises the significand so that
//   the hidden bit sits at SIG_WIDTH-2. This takes one right shift when there is
//   a carry, or a left shift by the leading-zero distance otherwise. The
//   exponent is adjusted to match, and the block flags zero, overflow and
//   underflow.
//
//   Stage 1 registers the beat and the leading-one position of the significand.
//   Stage 2 registers the shifted fields, the adjusted exponent and the flags.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_sign             sign, passed through unchanged
//   in_exponent         biased exponent of in_significand
//   in_significand      unnormalised significand (carry bit at MSB)
//   out_valid/out_ready output handshake
//   out_sign            sign
//   out_exponent        normalised exponent
//   out_mantissa        fraction without the hidden bit
//   out_rounding_bits   bits below the mantissa, LSB carries the sticky bit
//   out_zero            significand was exactly zero
//   out_overflow        exponent overflowed; result encodes infinity
//   out_underflow       exponent underflowed; result flushed to zero
//
// Handshake: a beat transfers on any cycle where valid && ready. A valid
// source holds its payload stable until the transfer. A stage advances
// whenever its downstream slot is empty or is draining in the same cycle.
// in_ready therefore depends only on internal state and out_ready, never on
// in_valid.
// -----------------------------------------------------------------------------
module result_normalizer #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = 3
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic                                         in_sign,
  input  logic [EXPONENT_WIDTH-1:0]                    in_exponent,
  input  logic [MANTISSA_WIDTH+ROUNDING_BITS+2-1:0]    in_significand,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_sign,
  output logic [EXPONENT_WIDTH-1:0]                    out_exponent,
  output logic [MANTISSA_WIDTH-1:0]                    out_mantissa,
  output logic [ROUNDING_BITS-1:0]                     out_rounding_bits,
  output logic                                         out_zero,
  output logic                                         out_overflow,
  output logic                                         out_underflow
);

  localparam int SIG_WIDTH = MANTISSA_WIDTH + ROUNDING_BITS + 2;
  localparam int LW        = $clog2(SIG_WIDTH);
  localparam int EW2       = EXPONENT_WIDTH + 2;

  // Exponent limits in the widened signed domain.
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXPONENT_WIDTH) - 1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;
  localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);

  // Position of the highest set bit; 0 when the input is zero.
  function automatic logic [LW-1:0] lead_one(input logic [SIG_WIDTH-1:0] s);
    logic [LW-1:0] pos;
    pos = '0;
    for (int i = 0; i < SIG_WIDTH; i++) begin
      if (s[i]) pos = LW'(i);
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic rdy_q;        // 0 during reset, 1 from the first edge after release
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_free;      // output slot empty or draining this cycle
  logic s1_advance;
  logic in_accept;

  assign s2_free    = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_free;
  assign in_ready   = rdy_q && (!s1_valid_q || s1_advance);
  assign in_accept  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_accept)       s1_valid_d = 1'b1;
    else if (s1_advance) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_free) s2_valid_d = s1_valid_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the beat and its leading-one position
  // ---------------------------------------------------------------------------
  logic                      s1_sign_q;
  logic [EXPONENT_WIDTH-1:0] s1_exp_q;
  logic [SIG_WIDTH-1:0]      s1_sig_q;
  logic [LW-1:0]             s1_lead_q;
  logic                      s1_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_lead_q  <= '0;
      s1_zero_q  <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      if (in_accept) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= in_exponent;
        s1_sig_q  <= in_significand;
        s1_lead_q <= lead_one(in_significand);
        s1_zero_q <= (in_significand == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: shift, exponent adjust, field extraction, flags
  // ---------------------------------------------------------------------------
  logic                      carry;
  logic                      sticky;
  logic [LW-1:0]             shamt;
  logic [SIG_WIDTH-1:0]      n_norm;
  logic signed [EW2-1:0]     e_in;
  logic signed [EW2-1:0]     e_new;
  logic [MANTISSA_WIDTH-1:0] man_norm;
  logic [ROUNDING_BITS-1:0]  rnd_norm;
  logic                      unused_norm_hi;

  assign carry  = s1_sig_q[SIG_WIDTH-1];
  assign sticky = carry & s1_sig_q[0];
  // Only meaningful without a carry; then lead <= SIG_WIDTH-2 and this cannot wrap.
  assign shamt  = LW'(SIG_WIDTH - 2) - s1_lead_q;
  assign n_norm = carry ? (s1_sig_q >> 1) : (s1_sig_q << shamt);
  assign e_in   = signed'({2'b00, s1_exp_q});
  assign e_new  = carry ? (e_in + EXP_ONE)
                        : (e_in - signed'({{(EW2-LW){1'b0}}, shamt}));

  assign man_norm = n_norm[SIG_WIDTH-3 -: MANTISSA_WIDTH];
  // The bit lost by the carry shift folds into the sticky position.
  assign rnd_norm = n_norm[ROUNDING_BITS-1:0]
                  | {{(ROUNDING_BITS-1){1'b0}}, sticky};
  // Carry and hidden-bit positions are implied by normalisation.
  assign unused_norm_hi = ^n_norm[SIG_WIDTH-1 -: 2];

  logic [EXPONENT_WIDTH-1:0] s2_exp_d;
  logic [MANTISSA_WIDTH-1:0] s2_man_d;
  logic [ROUNDING_BITS-1:0]  s2_rnd_d;
  logic                      s2_zero_d, s2_ovf_d, s2_unf_d;

  // Zero has priority, so at most one flag is set per beat.
  always_comb begin
    s2_exp_d  = e_new[EXPONENT_WIDTH-1:0];
    s2_man_d  = man_norm;
    s2_rnd_d  = rnd_norm;
    s2_zero_d = 1'b0;
    s2_ovf_d  = 1'b0;
    s2_unf_d  = 1'b0;
    if (s1_zero_q) begin
      s2_exp_d  = '0;
      s2_man_d  = '0;
      s2_rnd_d  = '0;
      s2_zero_d = 1'b1;
    end else if (e_new >= EXP_MAX) begin
      s2_exp_d  = '1;
      s2_man_d  = '0;
      s2_rnd_d  = '0;
      s2_ovf_d  = 1'b1;
    end else if (e_new <= EXP_ZERO) begin
      s2_exp_d  = '0;
      s2_man_d  = '0;
      s2_rnd_d  = '0;
      s2_unf_d  = 1'b1;
    end
  end

  logic                      s2_sign_q;
  logic [EXPONENT_WIDTH-1:0] s2_exp_q;
  logic [MANTISSA_WIDTH-1:0] s2_man_q;
  logic [ROUNDING_BITS-1:0]  s2_rnd_q;
  logic                      s2_zero_q, s2_ovf_q, s2_unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_rnd_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_advance) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s2_exp_d;
        s2_man_q  <= s2_man_d;
        s2_rnd_q  <= s2_rnd_d;
        s2_zero_q <= s2_zero_d;
        s2_ovf_q  <= s2_ovf_d;
        s2_unf_q  <= s2_unf_d;
      end
    end
  end

  assign out_valid         = s2_valid_q;
  assign out_sign          = s2_sign_q;
  assign out_exponent      = s2_exp_q;
  assign out_mantissa      = s2_man_q;
  assign out_rounding_bits = s2_rnd_q;
  assign out_zero          = s2_zero_q;
  assign out_overflow      = s2_ovf_q;
  assign out_underflow     = s2_unf_q;

endmodule

// File: tb/tb_result_normalizer.sv
// -----------------------------------------------------------------------------
// Bench for result_normalizer (EXP_W=8, MAN_W=23, RND_W=3, SIG_WIDTH=28).
// Output beats are packed as {sign, exp, mantissa, rounding, zero, ovf, unf}.
// -----------------------------------------------------------------------------
module tb_result_normalizer;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int RW = 3;
  localparam int SW = 28;
  localparam int OW = 1 + EW + MW + RW + 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sign;
  logic [EW-1:0] in_exponent;
  logic [SW-1:0] in_significand;
  logic          out_valid, out_ready, out_sign;
  logic [EW-1:0] out_exponent;
  logic [MW-1:0] out_mantissa;
  logic [RW-1:0] out_rounding_bits;
  logic          out_zero, out_overflow, out_underflow;

  always #5 clk = ~clk;

  result_normalizer #(
    .EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW), .ROUNDING_BITS(RW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_sign          (in_sign),
    .in_exponent      (in_exponent),
    .in_significand   (in_significand),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sign         (out_sign),
    .out_exponent     (out_exponent),
    .out_mantissa     (out_mantissa),
    .out_rounding_bits(out_rounding_bits),
    .out_zero         (out_zero),
    .out_overflow     (out_overflow),
    .out_underflow    (out_underflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  typedef struct {
    logic          sign;
    logic [EW-1:0] e;
    logic [SW-1:0] s;
    logic [OW-1:0] exp_out;
  } vec_t;

  vec_t vq[$];

  function automatic logic [OW-1:0] pack_out();
    return {out_sign, out_exponent, out_mantissa, out_rounding_bits,
            out_zero, out_overflow, out_underflow};
  endfunction

  function automatic logic [OW-1:0] mko(input logic sg, input logic [EW-1:0] e,
                                        input logic [MW-1:0] m, input logic [RW-1:0] r,
                                        input logic z, input logic o, input logic u);
    return {sg, e, m, r, z, o, u};
  endfunction

  function automatic vec_t mkv(input logic sg, input logic [EW-1:0] e,
                               input logic [SW-1:0] s, input logic [OW-1:0] x);
    vec_t v;
    v.sign = sg; v.e = e; v.s = s; v.exp_out = x;
    return v;
  endfunction

  // Reference: normalise bit-by-bit on an integer exponent.
  function automatic logic [OW-1:0] ref_model(input logic sg, input logic [EW-1:0] e_in,
                                              input logic [SW-1:0] s);
    int            e;
    logic [SW-1:0] n;
    logic          st;
    if (s == '0) return mko(sg, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    e = int'(e_in);
    n = s;
    st = 1'b0;
    if (n[SW-1]) begin
      st = n[0];
      n  = n >> 1;
      e  = e + 1;
    end else begin
      while (!n[SW-2]) begin
        n = n << 1;
        e = e - 1;
      end
    end
    if (e >= 255) return mko(sg, 8'hff, '0, '0, 1'b0, 1'b1, 1'b0);
    if (e <= 0)   return mko(sg, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    return mko(sg, e[EW-1:0], n[SW-3 -: MW], n[RW-1:0] | {2'b00, st}, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_beat(input logic sg, input logic [EW-1:0] e, input logic [SW-1:0] s);
    in_valid       = 1'b1;
    in_sign        = sg;
    in_exponent    = e;
    in_significand = s;
  endtask

  // Single beat with out_ready high: checks acceptance, 2-cycle latency and fields.
  task automatic apply_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_beat(v.sign, v.e, v.s);
    @(negedge clk);
    check($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d out_valid_lat1", idx), 64'(out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("vec%0d out_valid_lat2", idx), 64'(out_valid), 64'd1);
    check($sformatf("vec%0d fields", idx), 64'(pack_out()), 64'(v.exp_out));
  endtask

  // Random streaming with random backpressure against the reference model.
  task automatic stream(input int n_beats);
    int            sent = 0;
    int            got  = 0;
    int            cyc  = 0;
    logic          fired = 1'b0;
    logic          stalled = 1'b0;
    logic [OW-1:0] held_v = '0;
    logic [OW-1:0] e_v;
    logic [SW-1:0] s;
    logic [EW-1:0] e;
    int            k;
    in_valid = 1'b0;
    while ((sent < n_beats || exp_q.size() > 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || fired) begin
        if (sent < n_beats && $urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, 9);
          if (k == 0)      s = '0;
          else if (k == 1) s = 28'h8000000 | SW'($urandom);
          else             s = SW'($urandom) >> $urandom_range(0, SW - 1);
          k = $urandom_range(0, 5);
          if (k == 0)      e = 8'd0;
          else if (k == 1) e = 8'd255;
          else if (k == 2) e = 8'd254;
          else if (k == 3) e = 8'd1;
          else             e = EW'($urandom_range(0, 255));
          drive_beat(1'($urandom_range(0, 1)), e, s);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stalled) begin
        check("stream hold valid", 64'(out_valid), 64'd1);
        check("stream hold data", 64'(pack_out()), 64'(held_v));
      end
      fired = in_valid && in_ready;
      if (fired) begin
        exp_q.push_back(ref_model(in_sign, in_exponent, in_significand));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected beat", 64'(pack_out()), 64'd0);
          n_fail++;
        end else begin
          e_v = exp_q.pop_front();
          check($sformatf("stream beat%0d", got), 64'(pack_out()), 64'(e_v));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held_v  = pack_out();
    end
    in_valid = 1'b0;
    check("stream beats sent", 64'(sent), 64'(n_beats));
    check("stream beats received", 64'(got), 64'(n_beats));
    check("stream queue empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [OW-1:0] snap;
    logic [OW-1:0] ea, eb, ec;

    rst_n = 1'b0;
    in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0; in_significand = '0;
    out_ready = 1'b0;

    // Vector table: sign, E, S -> sign, E', mantissa, rounding, zero, ovf, unf.
    vq.push_back(mkv(0, 8'd127, 28'h8000001, mko(0, 8'd128, 23'h0,      3'd1, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd127, 28'h0000010, mko(0, 8'd105, 23'h0,      3'd0, 0, 0, 0)));
    vq.push_back(mkv(1, 8'd100, 28'h0000000, mko(1, 8'd0,   23'h0,      3'd0, 1, 0, 0)));
    vq.push_back(mkv(1, 8'd20,  28'h0000001, mko(1, 8'd0,   23'h0,      3'd0, 0, 0, 1)));
    vq.push_back(mkv(0, 8'd254, 28'h8000000, mko(0, 8'd255, 23'h0,      3'd0, 0, 1, 0)));
    vq.push_back(mkv(0, 8'd1,   28'h4000000, mko(0, 8'd1,   23'h0,      3'd0, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd254, 28'h4000000, mko(0, 8'd254, 23'h0,      3'd0, 0, 0, 0)));
    vq.push_back(mkv(1, 8'd255, 28'h4000000, mko(1, 8'd255, 23'h0,      3'd0, 0, 1, 0)));
    vq.push_back(mkv(0, 8'd100, 28'h7FFFFFF, mko(0, 8'd100, 23'h7FFFFF, 3'd7, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd100, 28'hFFFFFFF, mko(0, 8'd101, 23'h7FFFFF, 3'd7, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd10,  28'h8000006, mko(0, 8'd11,  23'h0,      3'd3, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd2,   28'h2000005, mko(0, 8'd1,   23'h1,      3'd2, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd1,   28'h2000005, mko(0, 8'd0,   23'h0,      3'd0, 0, 0, 1)));
    vq.push_back(mkv(0, 8'd200, 28'h0000003, mko(0, 8'd175, 23'h400000, 3'd0, 0, 0, 0)));
    vq.push_back(mkv(1, 8'd0,   28'h8000000, mko(1, 8'd1,   23'h0,      3'd0, 0, 0, 0)));
    vq.push_back(mkv(0, 8'd255, 28'h0000000, mko(0, 8'd0,   23'h0,      3'd0, 1, 0, 0)));

    // Reset state.
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset outputs", 64'(pack_out()), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after release", 64'(in_ready), 64'd1);

    // Directed table.
    for (int i = 0; i < vq.size(); i++) apply_vec(i, vq[i]);

    // Backpressure: 3 back-to-back beats against a stalled output.
    ea = ref_model(0, 8'd127, 28'h0000100);
    eb = ref_model(1, 8'd50,  28'h8000003);
    ec = ref_model(0, 8'd90,  28'h0123456);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_beat(0, 8'd127, 28'h0000100);
    @(negedge clk);
    check("bp accept A", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive_beat(1, 8'd50, 28'h8000003);
    @(negedge clk);
    check("bp accept B", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive_beat(0, 8'd90, 28'h0123456);
    snap = pack_out();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp stall%0d in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("bp stall%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp stall%0d hold", i), 64'(pack_out()), 64'(snap));
      @(posedge clk); #1;
    end
    check("bp head is A", 64'(snap), 64'(ea));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp out A valid", 64'(out_valid), 64'd1);
    check("bp out A", 64'(pack_out()), 64'(ea));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp out B valid", 64'(out_valid), 64'd1);
    check("bp out B", 64'(pack_out()), 64'(eb));
    @(negedge clk);
    check("bp out C valid", 64'(out_valid), 64'd1);
    check("bp out C", 64'(pack_out()), 64'(ec));
    @(negedge clk);
    check("bp drained", 64'(out_valid), 64'd0);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_beat(0, 8'd60, 28'h0F00000);
    @(posedge clk); #1;
    drive_beat(1, 8'd70, 28'h0000F00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset outputs", 64'(pack_out()), 64'd0);
    check("mid reset in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post reset no stale%0d", i), 64'(out_valid), 64'd0);
    end
    apply_vec(100, vq[9]);

    // Random streaming.
    stream(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
